// File: rtl/audio_mix_pkg.sv
// Shared constants and width helpers for the audio mixing tree.
package audio_mix_pkg;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Gain code that leaves a sample unchanged.
   function automatic int unity_gain_f(input int gain_w);
      return 1 << (gain_w - 1);
   endfunction

   // Signed width of the data leaving tree level `level` (level 0 = gain stage).
   function automatic int stage_w_f(input int in_w, input int level);
      return in_w + 1 + level;
   endfunction

   // Width of the saturated mix result.
   function automatic int sat_w_f(input int in_w, input int num_ch);
      return in_w + clog2_f(num_ch);
   endfunction

endpackage

// File: rtl/mix_add_stage.sv
// One registered level of the adder tree: sums adjacent signed pairs and
// widens each result by one bit so no level can overflow.
module mix_add_stage
   import audio_mix_pkg::*;
#(
   parameter int PAIRS = 2,
   parameter int W     = 9
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [2*PAIRS*W-1:0]   data_in,
   input  logic                   valid_in,
   output logic [PAIRS*(W+1)-1:0] data_out,
   output logic                   valid_out
);

   logic [PAIRS*(W+1)-1:0] sum_reg;
   logic [PAIRS*(W+1)-1:0] sum_next;
   logic                   valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < PAIRS; gi++) begin : g_pair
         assign sum_next[gi*(W+1) +: W+1] =
            (W+1)'($signed(data_in[(2*gi)*W +: W])) +
            (W+1)'($signed(data_in[(2*gi+1)*W +: W]));
      end
   endgenerate

   // Register the pair sums and shift the valid bit along with them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sum_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         sum_reg   <= sum_next;
         valid_reg <= valid_in;
      end
   end

   assign data_out  = sum_reg;
   assign valid_out = valid_reg;

endmodule

// File: rtl/audio_mix_tree.sv
// Pipelined N-channel audio mixer: per-channel gain/mute, registered binary
// adder tree, saturation to IN_W+log2(NUM_CH) bits and a sticky clip flag.
// NUM_CH must be a power of two (2..16); OUT_W must be >= IN_W+log2(NUM_CH).
module audio_mix_tree
   import audio_mix_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IN_W   = 8,
   parameter int GAIN_W = 4,
   parameter int OUT_W  = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_CH*IN_W-1:0]   audio_in,
   input  logic [NUM_CH*GAIN_W-1:0] gain,
   input  logic [NUM_CH-1:0]        mute,
   input  logic                     in_valid,
   input  logic                     clip_clr,
   output logic [OUT_W-1:0]         mix_down,
   output logic                     out_valid,
   output logic                     clip
);

   localparam int L          = clog2_f(NUM_CH);
   localparam int P_W        = stage_w_f(IN_W, 0);
   localparam int SUM_W      = stage_w_f(IN_W, L);
   localparam int S          = sat_w_f(IN_W, NUM_CH);
   localparam int PROD_W     = IN_W + GAIN_W;
   localparam int GAIN_SHIFT = clog2_f(unity_gain_f(GAIN_W));

   logic [NUM_CH*P_W-1:0] prod_reg;
   logic [NUM_CH*P_W-1:0] prod_next;
   logic                  prod_vld_reg;

   genvar gi;

   // Gain stage: product fits PROD_W bits, the arithmetic shift divides by
   // unity gain, and the result always fits IN_W+1 signed bits.
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_gain
         logic signed [PROD_W-1:0] smp_ext;
         logic signed [PROD_W-1:0] gain_ext;
         assign smp_ext  = PROD_W'($signed(audio_in[gi*IN_W +: IN_W]));
         assign gain_ext = PROD_W'({1'b0, gain[gi*GAIN_W +: GAIN_W]});
         assign prod_next[gi*P_W +: P_W] =
            mute[gi] ? '0 : P_W'((smp_ext * gain_ext) >>> GAIN_SHIFT);
      end
   endgenerate

   // Capture scaled samples only for accepted sets so later gain edits cannot
   // reach data already in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prod_reg     <= '0;
         prod_vld_reg <= 1'b0;
      end else begin
         prod_vld_reg <= in_valid;
         if (in_valid) prod_reg <= prod_next;
      end
   end

   // Adder tree: level gi consumes the previous level's bus.
   generate
      for (gi = 1; gi <= L; gi++) begin : g_lvl
         localparam int W_IN  = stage_w_f(IN_W, gi - 1);
         localparam int PAIRS = NUM_CH >> gi;
         logic [2*PAIRS*W_IN-1:0]  src;
         logic                     src_vld;
         logic [PAIRS*(W_IN+1)-1:0] sum;
         logic                     vld;
         if (gi == 1) begin : g_src_first
            assign src     = prod_reg;
            assign src_vld = prod_vld_reg;
         end else begin : g_src_next
            assign src     = g_lvl[gi-1].sum;
            assign src_vld = g_lvl[gi-1].vld;
         end
         mix_add_stage #(
            .PAIRS (PAIRS),
            .W     (W_IN)
         ) u_stage (
            .clk       (clk),
            .resetn    (resetn),
            .data_in   (src),
            .valid_in  (src_vld),
            .data_out  (sum),
            .valid_out (vld)
         );
      end
   endgenerate

   logic [SUM_W-1:0] sum_final;
   logic             sum_vld;
   logic [S-1:0]     sat_next;
   logic             sat_hit;

   assign sum_final = g_lvl[L].sum;
   assign sum_vld   = g_lvl[L].vld;

   // Clamp to S bits: the sum overflows S bits exactly when its top two bits differ.
   always_comb begin
      sat_hit  = sum_final[SUM_W-1] ^ sum_final[SUM_W-2];
      sat_next = sum_final[S-1:0];
      if (sat_hit)
         sat_next = sum_final[SUM_W-1] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
   end

   logic [OUT_W-1:0] mix_down_reg;
   logic             out_valid_reg;
   logic             clip_reg;

   // Output stage: MSB-align the mix, pulse out_valid, and keep clip sticky
   // with a new saturation taking priority over clip_clr.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mix_down_reg  <= '0;
         out_valid_reg <= 1'b0;
         clip_reg      <= 1'b0;
      end else begin
         out_valid_reg <= sum_vld;
         if (sum_vld) mix_down_reg <= OUT_W'(sat_next) << (OUT_W - S);
         if (sum_vld && sat_hit) clip_reg <= 1'b1;
         else if (clip_clr)      clip_reg <= 1'b0;
      end
   end

   assign mix_down  = mix_down_reg;
   assign out_valid = out_valid_reg;
   assign clip      = clip_reg;

endmodule

// File: tb/tb_audio_mix_tree.sv
// Self-checking bench for audio_mix_tree (NUM_CH=4, IN_W=8, GAIN_W=4, OUT_W=32).
module tb_audio_mix_tree;

   logic        clk;
   logic        resetn;
   logic [31:0] audio_in;
   logic [15:0] gain;
   logic [3:0]  mute;
   logic        in_valid;
   logic        clip_clr;
   logic [31:0] mix_down;
   logic        out_valid;
   logic        clip;

   int errors;
   int checks;
   logic [31:0] exp_q[$];

   audio_mix_tree #(
      .NUM_CH (4),
      .IN_W   (8),
      .GAIN_W (4),
      .OUT_W  (32)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .audio_in  (audio_in),
      .gain      (gain),
      .mute      (mute),
      .in_valid  (in_valid),
      .clip_clr  (clip_clr),
      .mix_down  (mix_down),
      .out_valid (out_valid),
      .clip      (clip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: floor(sample*gain/8) per unmuted channel, summed, clamped to 10 bits.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [15:0] g,
                                         input logic [3:0] m);
      int sum;
      int s;
      int gg;
      logic [9:0] t;
      sum = 0;
      for (int k = 0; k < 4; k++) begin
         s  = int'($signed(a[k*8 +: 8]));
         gg = int'(g[k*4 +: 4]);
         if (!m[k]) sum += (s * gg) >>> 3;
      end
      if (sum > 511)  sum = 511;
      if (sum < -512) sum = -512;
      t = sum[9:0];
      return {t, 22'b0};
   endfunction

   // Drive one sample set for one cycle; called and returns on a falling edge.
   task automatic send(input logic [31:0] a, input logic [15:0] g, input logic [3:0] m);
      audio_in = a;
      gain     = g;
      mute     = m;
      in_valid = 1'b1;
      exp_q.push_back(model(a, g, m));
      $display("send audio=%h gain=%h mute=%b", a, g, m);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      resetn   = 1'b1;
      audio_in = '0;
      gain     = '0;
      mute     = '0;
      in_valid = 1'b0;
      clip_clr = 1'b0;
      #3 resetn = 1'b0;
      #1;
      checks++;
      if (mix_down !== 32'd0) begin
         errors++;
         $display("FAIL reset_mix: got %h expected %h", mix_down, 32'd0);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (clip !== 1'b0) begin
         errors++;
         $display("FAIL reset_clip: got %b expected 0", clip);
      end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unity;
      int lat;
      bit got;
      logic [31:0] exp;
      send({4{8'd127}}, 16'h8888, 4'b0000);
      lat = 1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (out_valid) got = 1;
      end
      checks++;
      if (!got || lat != 4) begin
         errors++;
         $display("FAIL unity_latency: got %0d (seen=%0d) expected 4", lat, got);
      end
      exp = exp_q.pop_front();
      checks++;
      if (mix_down !== exp || mix_down !== (32'd508 << 22)) begin
         errors++;
         $display("FAIL unity_mix: got %h expected %h", mix_down, 32'd508 << 22);
      end
      checks++;
      if (clip !== 1'b0) begin
         errors++;
         $display("FAIL unity_clip: got %b expected 0", clip);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || mix_down !== (32'd508 << 22)) begin
         errors++;
         $display("FAIL unity_pulse_hold: got valid=%b mix=%h expected valid=0 mix=%h",
                  out_valid, mix_down, 32'd508 << 22);
      end
   endtask

   task automatic test_saturate(input logic [31:0] a, input logic [31:0] want, input string name);
      bit got;
      logic [31:0] exp;
      send(a, 16'hFFFF, 4'b0000);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (out_valid) got = 1;
      end
      exp = exp_q.pop_front();
      checks++;
      if (!got || mix_down !== exp || mix_down !== want) begin
         errors++;
         $display("FAIL %s_mix: got %h (seen=%0d) expected %h", name, mix_down, got, want);
      end
      checks++;
      if (clip !== 1'b1) begin
         errors++;
         $display("FAIL %s_clip_set: got %b expected 1", name, clip);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (clip !== 1'b1) begin
         errors++;
         $display("FAIL %s_clip_sticky: got %b expected 1", name, clip);
      end
      clip_clr = 1'b1;
      @(negedge clk);
      clip_clr = 1'b0;
      checks++;
      if (clip !== 1'b0) begin
         errors++;
         $display("FAIL %s_clip_clr: got %b expected 0", name, clip);
      end
   endtask

   task automatic test_mute;
      bit got;
      logic [31:0] exp;
      for (int r = 0; r < 2; r++) begin
         if (r == 0) send({4{8'd100}}, 16'h8888, 4'b0001);
         else        send({4{8'd100}}, 16'h8880, 4'b0000);
         got = 0;
         for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (out_valid) got = 1;
         end
         exp = exp_q.pop_front();
         checks++;
         if (!got || mix_down !== exp || mix_down !== (32'd300 << 22)) begin
            errors++;
            $display("FAIL mute_run%0d: got %h (seen=%0d) expected %h",
                     r, mix_down, got, 32'd300 << 22);
         end
      end
   endtask

   task automatic test_back_to_back;
      int n_out;
      int first_c;
      int last_c;
      logic [31:0] a;
      logic [15:0] g;
      logic [31:0] exp;
      n_out   = 0;
      first_c = -1;
      last_c  = -1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               for (int k = 0; k < 4; k++) begin
                  a[k*8 +: 8] = 8'(i*25 + k*9 - 100);
                  g[k*4 +: 4] = 4'((i + k*3) % 16);
               end
               audio_in = a;
               gain     = g;
               mute     = (i == 3) ? 4'b0100 : 4'b0000;
               in_valid = 1'b1;
               exp_q.push_back(model(a, g, mute));
               $display("send audio=%h gain=%h mute=%b", a, g, mute);
               @(negedge clk);
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 30; c++) begin
               @(negedge clk);
               if (out_valid) begin
                  if (first_c < 0) first_c = c;
                  last_c = c;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_extra: got unexpected out_valid mix=%h expected none", mix_down);
                  end else begin
                     exp = exp_q.pop_front();
                     if (mix_down !== exp) begin
                        errors++;
                        $display("FAIL b2b_sample%0d: got %h expected %h", n_out, mix_down, exp);
                     end
                  end
                  n_out++;
               end
            end
         end
      join
      checks++;
      if (n_out != 10 || (last_c - first_c) != 9) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses over span %0d expected 10 over span 9",
                  n_out, last_c - first_c);
      end
      clip_clr = 1'b1;
      @(negedge clk);
      clip_clr = 1'b0;
   endtask

   task automatic test_clip_set_wins;
      logic [31:0] exp;
      send({4{8'd127}}, 16'hFFFF, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      clip_clr = 1'b1;
      @(negedge clk);
      clip_clr = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || mix_down !== exp) begin
         errors++;
         $display("FAIL setwins_mix: got valid=%b mix=%h expected valid=1 mix=%h",
                  out_valid, mix_down, exp);
      end
      checks++;
      if (clip !== 1'b1) begin
         errors++;
         $display("FAIL setwins_clip: got %b expected 1", clip);
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      int lat;
      bit got;
      logic [31:0] exp;
      send({4{8'd50}}, 16'h8888, 4'b0000);
      @(negedge clk);
      resetn = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if (mix_down !== 32'd0 || out_valid !== 1'b0 || clip !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: got mix=%h valid=%b clip=%b expected all 0",
                  mix_down, out_valid, clip);
      end
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0 || mix_down !== 32'd0) begin
         errors++;
         $display("FAIL midreset_discard: got %0d pulses mix=%h expected 0 pulses mix=0",
                  seen, mix_down);
      end
      send({8'd10, 8'd20, 8'd30, 8'd40}, 16'h8888, 4'b0000);
      lat = 1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (out_valid) got = 1;
      end
      exp = exp_q.pop_front();
      checks++;
      if (!got || lat != 4 || mix_down !== exp || mix_down !== (32'd100 << 22)) begin
         errors++;
         $display("FAIL midreset_fresh: got lat=%0d mix=%h expected lat=4 mix=%h",
                  lat, mix_down, 32'd100 << 22);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_unity();
      test_saturate({4{8'd127}}, 32'd511 << 22, "sat_pos");
      test_saturate({4{8'h80}}, 32'h8000_0000, "sat_neg");
      test_mute();
      test_back_to_back();
      test_clip_set_wins();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_mix_tree.md
AUDIO_MIX_TREE -- requirements
Module: audio_mix_tree

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels; SHALL be a power of two from 2 to 16.
REQ-002 Parameter IN_W, default 8: sample width per channel, signed two's complement.
REQ-003 Parameter GAIN_W, default 4: per-channel unsigned gain width; unity gain = 2^(GAIN_W-1).
REQ-004 Parameter OUT_W, default 32: mix_down width; SHALL be >= IN_W+log2(NUM_CH).
REQ-005 Port clk, input, 1: single clock, all logic rising-edge.
REQ-006 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-007 Port audio_in, input, NUM_CH*IN_W: channel k at bits [k*IN_W +: IN_W].
REQ-008 Port gain, input, NUM_CH*GAIN_W: channel k gain at bits [k*GAIN_W +: GAIN_W].
REQ-009 Port mute, input, NUM_CH: bit k forces channel k contribution to 0.
REQ-010 Port in_valid, input, 1: audio_in, gain and mute are sampled on cycles where it is high.
REQ-011 Port mix_down, output, OUT_W: saturated mix, MSB-aligned, low bits zero.
REQ-012 Port out_valid, output, 1: one-cycle pulse marking a new mix_down value.
REQ-013 Port clip, output, 1: sticky flag, set when any output sample saturated.
REQ-014 Port clip_clr, input, 1: synchronous clear of clip.

Function
REQ-015 Stage 0 (gain stage) SHALL register, per channel, (sample * gain) arithmetically shifted right by GAIN_W-1, giving IN_W+1 signed bits; the value is 0 when mute is set.
REQ-016 Stages 1..L, where L = log2(NUM_CH), SHALL form a registered binary adder tree; each level adds adjacent pairs and grows width by 1 bit, so the sum is IN_W+1+L bits.
REQ-017 The final stage SHALL saturate the sum to S = IN_W+L signed bits: values above 2^(S-1)-1 clamp to that value; values below -2^(S-1) clamp to -2^(S-1).
REQ-018 mix_down SHALL equal the saturated value concatenated with OUT_W-S zero bits.
REQ-019 Latency SHALL be L+2 cycles from an in_valid cycle to its out_valid pulse (4 cycles at NUM_CH=4).
REQ-020 Throughput SHALL be one sample set per cycle; in_valid may be high on consecutive cycles, and there is no backpressure.
REQ-021 A valid bit SHALL shift alongside the data; out_valid equals the valid bit of the final stage.
REQ-022 mix_down SHALL update only when the final stage is valid and hold its value otherwise.
REQ-023 clip SHALL be set on the cycle out_valid is asserted with a saturated value.
REQ-024 If clip_clr and a new saturation event occur in the same cycle, set SHALL win.
REQ-025 Gain and mute changes SHALL take effect only on sample sets accepted after the change; sets already in flight are unaffected.
REQ-026 Gain of 0 SHALL behave identically to mute.

Reset
REQ-027 Asserting resetn low SHALL asynchronously clear all pipeline data, all valid bits, mix_down, out_valid and clip to 0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight samples; no out_valid pulse may occur for samples accepted before reset.
REQ-029 The first out_valid after reset release SHALL occur exactly L+2 cycles after the first in_valid.

Structure
REQ-030 Package audio_mix_pkg SHALL hold the unity-gain constant function, a clog2 helper, and the derived-width helpers (stage widths, S).
REQ-031 One tree level SHALL be a sub-module mix_add_stage, parametrised by pair count and input width and instantiated L times via generate.

Verification
REQ-032 All gain=8, no mute, every channel=127, one in_valid -> out_valid 4 cycles later; mix_down = 508<<22; clip stays 0.
REQ-033 All gain=15, every channel=127 -> sum 952 saturates to 511; mix_down = 511<<22; clip=1 until clip_clr is pulsed.
REQ-034 Channels {-128,-128,-128,-128}, gain=15 -> saturate to -512 (mix_down = 0x80000000); clip set.
REQ-035 mute=4'b0001, all channels=100, gain=8 -> mix_down = 300<<22; repeat with gain[0]=0 -> same result.
REQ-036 in_valid high for 10 consecutive cycles with ramp inputs -> 10 consecutive out_valid pulses, in order, each matching the reference model.
REQ-037 resetn pulsed low 2 cycles after in_valid -> no out_valid pulse, all outputs 0; a fresh in_valid after release yields out_valid 4 cycles later.
